// File: rtl/fp2_pkg.sv
// Shared constants and types for the Fp2 operand loading path.
// Operand select codes map directly onto the one-hot memory write enables.
package fp2_pkg;

  localparam int FP2_RADIX      = 32;
  localparam int FP2_WIDTH_REAL = 12;
  localparam int FP2_CNT_W      = 16;

  localparam logic [1:0] OPSEL_A0 = 2'd0;
  localparam logic [1:0] OPSEL_A1 = 2'd1;
  localparam logic [1:0] OPSEL_B0 = 2'd2;
  localparam logic [1:0] OPSEL_B1 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } loader_state_t;

  // bit0 a0, bit1 a1, bit2 b0, bit3 b1
  function automatic logic [3:0] opsel_onehot(input logic [1:0] sel);
    logic [3:0] en;
    case (sel)
      OPSEL_A0: en = 4'b0001;
      OPSEL_A1: en = 4'b0010;
      OPSEL_B0: en = 4'b0100;
      default:  en = 4'b1000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/fp2_operand_loader_if.sv
// Digit stream into the operand loader.
// A digit transfers on every rising clock edge where in_valid and in_ready are both high;
// the master holds in_data stable while in_valid is high, and ready may drop without warning.
interface fp2_operand_loader_if #(
  parameter int RADIX = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [RADIX-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fp2_operand_loader.sv
// Streams RADIX-bit digits LSD-first into the a0/a1/b0/b1 memories, then starts the
// Fp2 multiplier and holds off new input until it reports done.
module fp2_operand_loader
  import fp2_pkg::*;
#(
  parameter int RADIX      = FP2_RADIX,
  parameter int WIDTH_REAL = FP2_WIDTH_REAL,
  parameter int CNT_W      = FP2_CNT_W,
  localparam int ADDR_W    = (WIDTH_REAL > 1) ? $clog2(WIDTH_REAL) : 1
) (
  input  logic                  io_mainClk,
  input  logic                  io_systemReset,
  fp2_operand_loader_if.slave   s_in,
  input  logic                  abort,
  output logic [3:0]            mem_wr_en,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [RADIX-1:0]      mem_din,
  output logic                  mult_rst,
  output logic                  mult_start,
  input  logic                  mult_done,
  output logic                  busy,
  output logic                  op_done,
  output logic [CNT_W-1:0]      op_count,
  output loader_state_t         state_dbg
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(WIDTH_REAL - 1);

  loader_state_t     state;
  logic [1:0]        sel;
  logic [ADDR_W-1:0] cnt;
  logic              xfer;

  assign s_in.in_ready = (state == IDLE) || (state == LOAD);
  assign xfer          = s_in.in_valid && s_in.in_ready;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  always_ff @(posedge io_mainClk) begin
    if (io_systemReset) begin
      state       <= IDLE;
      sel         <= OPSEL_A0;
      cnt         <= '0;
      mem_wr_en   <= '0;
      mem_wr_addr <= '0;
      mem_din     <= '0;
      mult_rst    <= 1'b0;
      mult_start  <= 1'b0;
      op_done     <= 1'b0;
      op_count    <= '0;
    end else if (abort) begin
      // Abort drops any same-cycle transfer and resets the multiplier, keeping op_count.
      state      <= IDLE;
      sel        <= OPSEL_A0;
      cnt        <= '0;
      mem_wr_en  <= '0;
      mult_rst   <= 1'b1;
      mult_start <= 1'b0;
      op_done    <= 1'b0;
    end else begin
      mem_wr_en  <= '0;
      mult_rst   <= 1'b0;
      mult_start <= 1'b0;
      op_done    <= 1'b0;

      if (xfer) begin
        mem_wr_en   <= opsel_onehot(sel);
        mem_wr_addr <= cnt;
        mem_din     <= s_in.in_data;
      end

      case (state)
        IDLE, LOAD: begin
          if (xfer) begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (sel == OPSEL_B1) begin
                state <= START;
              end else begin
                sel   <= sel + 2'd1;
                state <= LOAD;
              end
            end else begin
              cnt   <= cnt + ADDR_W'(1);
              state <= LOAD;
            end
          end
        end
        START: begin
          // One cycle of slack so the final digit's write lands before the start pulse.
          sel        <= OPSEL_A0;
          mult_start <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          // A done pulse overlapping our own start belongs to no operation of ours.
          if (mult_done && !mult_start) begin
            op_done  <= 1'b1;
            op_count <= op_count + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp2_operand_loader.sv
// Directed bench for fp2_operand_loader: full loads, backpressure, bubbles, abort,
// spurious mult_done and mid-operation reset, with a write scoreboard.
module tb_fp2_operand_loader;
  import fp2_pkg::*;

  localparam int RADIX  = FP2_RADIX;
  localparam int WR     = FP2_WIDTH_REAL;
  localparam int DIGITS = 4 * WR;
  localparam int AW     = $clog2(WR);
  localparam int CW     = FP2_CNT_W;
  localparam int W      = 4 + AW + RADIX;

  // ---------------- clock / reset ----------------
  logic io_mainClk = 1'b0;
  logic io_systemReset = 1'b1;
  logic abort = 1'b0;
  logic mult_done = 1'b0;
  int   cyc = 0;

  always #5 io_mainClk = ~io_mainClk;
  always @(posedge io_mainClk) cyc <= cyc + 1;

  fp2_operand_loader_if #(.RADIX(RADIX)) s_if ();

  logic [3:0]       mem_wr_en;
  logic [AW-1:0]    mem_wr_addr;
  logic [RADIX-1:0] mem_din;
  logic             mult_rst, mult_start, busy, op_done;
  logic [CW-1:0]    op_count;
  loader_state_t    state_dbg;

  fp2_operand_loader dut (
    .io_mainClk     (io_mainClk),
    .io_systemReset (io_systemReset),
    .s_in           (s_if),
    .abort          (abort),
    .mem_wr_en      (mem_wr_en),
    .mem_wr_addr    (mem_wr_addr),
    .mem_din        (mem_din),
    .mult_rst       (mult_rst),
    .mult_start     (mult_start),
    .mult_done      (mult_done),
    .busy           (busy),
    .op_done        (op_done),
    .op_count       (op_count),
    .state_dbg      (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] wr_log[$];
  int wr_cnt = 0, start_cnt = 0, start_cyc = 0, done_cnt = 0, rst_cnt = 0;
  int model_k = 0;
  int xfer_cyc = 0;

  always @(negedge io_mainClk) begin
    if (mem_wr_en != 4'b0000) begin
      wr_cnt++;
      wr_log.push_back({mem_wr_en, mem_wr_addr, mem_din});
      if (exp_q.size() == 0) check("wr_extra", {mem_wr_en, mem_wr_addr, mem_din}, '0);
      else check("wr", {mem_wr_en, mem_wr_addr, mem_din}, exp_q.pop_front());
    end
    if (mult_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (op_done)  done_cnt++;
    if (mult_rst) rst_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge io_mainClk);
      #1;
    end
  endtask

  task automatic send_digit(input logic [RADIX-1:0] d, input int gap);
    logic [3:0]    e;
    logic [AW-1:0] a;
    bit            sent;
    sent = 1'b0;
    step(gap);
    s_if.in_valid = 1'b1;
    s_if.in_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge io_mainClk);
      if (s_if.in_ready) begin
        e = 4'b0001 << (model_k / WR);
        a = AW'(model_k % WR);
        exp_q.push_back({e, a, d});
        model_k  = (model_k == DIGITS - 1) ? 0 : model_k + 1;
        xfer_cyc = cyc;
        @(posedge io_mainClk);
        #1;
        sent = 1'b1;
        break;
      end
      @(posedge io_mainClk);
      #1;
    end
    s_if.in_valid = 1'b0;
    if (!sent) check("xfer_timeout", s_if.in_ready, 1);
  endtask

  task automatic load(input logic [RADIX-1:0] base, input int first, input int n, input bit gaps);
    for (int k = first; k < first + n; k++)
      send_digit(base + RADIX'(k), gaps ? int'($urandom_range(0, 1)) : 0);
  endtask

  task automatic pulse_done();
    mult_done = 1'b1;
    step(1);
    mult_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int s0, d0, r0, w0, ready_hi;

  initial begin
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    step(3);
    io_systemReset = 1'b0;
    @(negedge io_mainClk);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_start", mult_start, 0);
    check("rst_mrst", mult_rst, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_ready", s_if.in_ready, 1);
    check("rst_state", state_dbg, IDLE);
    step(1);

    // Test 1: full back-to-back load
    wr_log.delete();
    s0 = start_cnt;
    load(32'h1000_0000, 0, DIGITS, 1'b0);
    step(3);
    check("t1_nwr", wr_log.size(), 48);
    check("t1_k13", wr_log[13], 40'h21_1000_000D);
    check("t1_k47", wr_log[47], 40'h8B_1000_002F);
    check("t1_start_cnt", start_cnt, s0 + 1);
    check("t1_start_lat", start_cyc, xfer_cyc + 2);
    check("t1_state", state_dbg, WAIT);
    check("t1_busy", busy, 1);
    check("t1_sb_empty", exp_q.size(), 0);

    // Test 2: backpressure during WAIT, then completion
    w0 = wr_cnt;
    ready_hi = 0;
    s_if.in_valid = 1'b1;
    s_if.in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 50; i++) begin
      @(negedge io_mainClk);
      if (s_if.in_ready) ready_hi++;
      @(posedge io_mainClk);
      #1;
    end
    s_if.in_valid = 1'b0;
    check("t2_ready_hi", ready_hi, 0);
    check("t2_no_wr", wr_cnt, w0);
    d0 = done_cnt;
    pulse_done();
    @(negedge io_mainClk);
    check("t2_op_done", op_done, 1);
    check("t2_op_count", op_count, 1);
    check("t2_ready", s_if.in_ready, 1);
    check("t2_busy", busy, 0);
    step(2);
    check("t2_done_once", done_cnt, d0 + 1);

    // Test 3: random bubbles
    wr_log.delete();
    s0 = start_cnt;
    load(32'h2000_0000, 0, DIGITS, 1'b1);
    step(3);
    check("t3_nwr", wr_log.size(), 48);
    check("t3_k0", wr_log[0], 40'h10_2000_0000);
    check("t3_k24", wr_log[24], 40'h40_2000_0018);
    check("t3_start_cnt", start_cnt, s0 + 1);
    check("t3_sb_empty", exp_q.size(), 0);
    pulse_done();
    @(negedge io_mainClk);
    check("t3_op_count", op_count, 2);
    step(1);

    // Test 4: abort after 17 digits, with a discarded transfer in the abort cycle
    r0 = rst_cnt;
    s0 = start_cnt;
    load(32'h3000_0000, 0, 17, 1'b0);
    abort = 1'b1;
    s_if.in_valid = 1'b1;
    s_if.in_data  = 32'hBAD0_0000;
    step(1);
    abort = 1'b0;
    s_if.in_valid = 1'b0;
    @(negedge io_mainClk);
    check("t4_mult_rst", mult_rst, 1);
    check("t4_state", state_dbg, IDLE);
    check("t4_wr_en", mem_wr_en, 0);
    step(1);
    @(negedge io_mainClk);
    check("t4_mult_rst_low", mult_rst, 0);
    check("t4_rst_once", rst_cnt, r0 + 1);
    check("t4_op_count", op_count, 2);
    check("t4_sb_empty", exp_q.size(), 0);
    step(1);
    model_k = 0;
    wr_log.delete();
    load(32'h4000_0000, 0, DIGITS - 1, 1'b0);
    step(5);
    check("t4_first_wr", wr_log[0], 40'h10_4000_0000);
    check("t4_no_start_47", start_cnt, s0);
    check("t4_busy_47", busy, 1);
    load(32'h4000_0000, DIGITS - 1, 1, 1'b0);
    step(3);
    check("t4_start_48", start_cnt, s0 + 1);
    check("t4_start_lat", start_cyc, xfer_cyc + 2);
    pulse_done();
    @(negedge io_mainClk);
    check("t4_op_count_end", op_count, 3);
    step(1);

    // Test 5: spurious mult_done in IDLE, LOAD and coincident with mult_start
    d0 = done_cnt;
    pulse_done();
    step(2);
    check("t5_idle_done", done_cnt, d0);
    check("t5_idle_state", state_dbg, IDLE);
    load(32'h5000_0000, 0, 5, 1'b0);
    pulse_done();
    step(2);
    check("t5_load_done", done_cnt, d0);
    check("t5_load_state", state_dbg, LOAD);
    load(32'h5000_0000, 5, DIGITS - 5, 1'b0);
    step(1);
    pulse_done();
    @(negedge io_mainClk);
    check("t5_coinc_lat", start_cyc, xfer_cyc + 2);
    step(3);
    check("t5_coinc_done", done_cnt, d0);
    check("t5_coinc_state", state_dbg, WAIT);
    check("t5_op_count", op_count, 3);
    pulse_done();
    @(negedge io_mainClk);
    check("t5_op_count_end", op_count, 4);
    step(1);

    // Test 6: reset in the middle of WAIT
    load(32'h6000_0000, 0, DIGITS, 1'b0);
    step(4);
    check("t6_pre_state", state_dbg, WAIT);
    io_systemReset = 1'b1;
    step(1);
    io_systemReset = 1'b0;
    @(negedge io_mainClk);
    check("t6_state", state_dbg, IDLE);
    check("t6_outs", {mem_wr_en, mem_wr_addr, mem_din, mult_rst, mult_start, busy, op_done}, '0);
    check("t6_op_count", op_count, 0);
    step(1);
    model_k = 0;
    s0 = start_cnt;
    load(32'h7000_0000, 0, DIGITS, 1'b0);
    step(3);
    check("t6_start", start_cnt, s0 + 1);
    pulse_done();
    @(negedge io_mainClk);
    check("t6_op_count_end", op_count, 1);
    step(2);
    check("final_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
